wb16_slave_decoder: RTL

- Registered address decoder and sequencer for the 16-bit Wishbone B3 bus that sits behind the width-reduction stage and bridge.
- Replaces the combinational stb/ack/data muxing currently used there.
- Routes one master cycle to one of four slaves: RAM, GPIA, REMEX and ROM.
- Completes accesses to unmapped regions itself.
- Bounds every access with a watchdog, so a dead slave cannot hang the CPU.

---
 rtl/wb16_pkg.sv | 30 +++
 rtl/wb16_bus_watchdog.sv | 31 +++
 rtl/wb16_slave_decoder.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/wb16_pkg.sv
// Shared types and constants for the 16-bit Wishbone slave decoder.
package wb16_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int NUM_SLAVES = 4;
  localparam int SLV_IDX_W  = 2;

  typedef logic [SLV_IDX_W-1:0] slv_idx_t;

  localparam slv_idx_t SLV_RAM   = 2'd0;
  localparam slv_idx_t SLV_GPIA  = 2'd1;
  localparam slv_idx_t SLV_REMEX = 2'd2;
  localparam slv_idx_t SLV_ROM   = 2'd3;

  localparam logic [3:0] DEF_REGION0 = 4'h0;
  localparam logic [3:0] DEF_REGION1 = 4'h1;
  localparam logic [3:0] DEF_REGION2 = 4'h2;
  localparam logic [3:0] DEF_REGION3 = 4'hF;

  // One-hot strobe pattern for a slave index.
  function automatic logic [NUM_SLAVES-1:0] slave_onehot(input slv_idx_t idx);
    slave_onehot = NUM_SLAVES'(1) << idx;
  endfunction

endpackage

// File: rtl/wb16_bus_watchdog.sv
// Saturating access watchdog: counts enabled cycles since the last clear and
// flags when the count has reached TIMEOUT. It never wraps.
module wb16_bus_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] count_reg;

  // Counter: clear wins over enable, holds once it reaches the limit.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en && (count_reg != LIMIT)) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign expired = (count_reg == LIMIT);

endmodule

// File: rtl/wb16_slave_decoder.sv
// Registered address decoder / sequencer for the 16-bit Wishbone bus.
// Routes one master cycle to RAM, GPIA, REMEX or ROM, completes unmapped
// accesses locally and forces completion of accesses a slave never acks.
// Build option: define WB16_DECODER_ERR_EN to signal unmapped and timed-out
// completions on m_err_o instead of m_ack_o.
module wb16_slave_decoder
  import wb16_pkg::*;
#(
  parameter int          ADR_W        = 24,
  parameter logic [3:0]  REGION0      = DEF_REGION0,
  parameter logic [3:0]  REGION1      = DEF_REGION1,
  parameter logic [3:0]  REGION2      = DEF_REGION2,
  parameter logic [3:0]  REGION3      = DEF_REGION3,
  parameter int          TIMEOUT      = 255,
  parameter logic [15:0] UNMAPPED_DAT = 16'h0000
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [ADR_W-1:0]      m_adr_i,
  input  logic                  m_cyc_i,
  input  logic                  m_stb_i,
  input  logic                  m_we_i,
  output logic                  m_ack_o,
  output logic                  m_err_o,
  output logic [15:0]           m_dat_o,
  output logic [NUM_SLAVES-1:0] s_stb_o,
  input  logic [NUM_SLAVES-1:0] s_ack_i,
  input  logic [16*NUM_SLAVES-1:0] s_dat_i
);

  state_t                  state_reg, state_next;
  slv_idx_t                sel_reg, sel_next;
  logic [NUM_SLAVES-1:0]   stb_reg, stb_next;
  logic                    ack_reg, ack_next;
  logic [15:0]             dat_reg, dat_next;
`ifdef WB16_DECODER_ERR_EN
  logic                    err_reg, err_next;
`endif

  logic [3:0]              region_field;
  logic [3:0]              region_code [NUM_SLAVES];
  logic [NUM_SLAVES-1:0]   region_match;
  logic [15:0]             slave_dat [NUM_SLAVES];
  logic                    hit;
  slv_idx_t                hit_idx;
  logic                    wd_clr, wd_en, wd_expired;

  // The write enable and the low address bits go straight to the slaves
  // outside this block; the decoder itself never looks at them.
  logic unused_inputs;
  assign unused_inputs = ^{m_we_i, m_adr_i[ADR_W-5:0]};

  assign region_field = m_adr_i[ADR_W-1 -: 4];

  assign region_code[SLV_RAM]   = REGION0;
  assign region_code[SLV_GPIA]  = REGION1;
  assign region_code[SLV_REMEX] = REGION2;
  assign region_code[SLV_ROM]   = REGION3;

  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
    assign region_match[gi] = (region_field == region_code[gi]);
    assign slave_dat[gi]    = s_dat_i[16*gi +: 16];
  end

  // Priority encode the region matches; the lowest index wins on duplicates.
  always_comb begin
    hit     = |region_match;
    hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (region_match[i]) hit_idx = slv_idx_t'(i);
    end
  end

  wb16_bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  // Next-state and registered-output logic for the access sequencer.
  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    stb_next   = stb_reg;
    ack_next   = 1'b0;
    dat_next   = dat_reg;
    wd_clr     = 1'b0;
    wd_en      = 1'b0;
`ifdef WB16_DECODER_ERR_EN
    err_next   = 1'b0;
`endif
    unique case (state_reg)
      IDLE: begin
        if (m_cyc_i && m_stb_i) begin
          if (hit) begin
            sel_next   = hit_idx;
            stb_next   = slave_onehot(hit_idx);
            wd_clr     = 1'b1;
            state_next = ACCESS;
          end else begin
            dat_next   = UNMAPPED_DAT;
`ifdef WB16_DECODER_ERR_EN
            err_next   = 1'b1;
`else
            ack_next   = 1'b1;
`endif
            state_next = DONE;
          end
        end
      end
      ACCESS: begin
        wd_en = 1'b1;
        if (!m_cyc_i) begin
          // Master abort: drop the access without completing it.
          stb_next   = '0;
          state_next = IDLE;
        end else if (s_ack_i[sel_reg]) begin
          // A real ack beats a timeout expiring in the same cycle.
          dat_next   = slave_dat[sel_reg];
          ack_next   = 1'b1;
          stb_next   = '0;
          state_next = DONE;
        end else if (wd_expired) begin
          dat_next   = UNMAPPED_DAT;
`ifdef WB16_DECODER_ERR_EN
          err_next   = 1'b1;
`else
          ack_next   = 1'b1;
`endif
          stb_next   = '0;
          state_next = DONE;
        end
      end
      DONE: begin
        // Always pass through IDLE so the next strobe is sampled afresh.
        state_next = IDLE;
      end
      default: begin
        stb_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight access silently.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_reg <= IDLE;
      sel_reg   <= '0;
      stb_reg   <= '0;
      ack_reg   <= 1'b0;
      dat_reg   <= '0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      stb_reg   <= stb_next;
      ack_reg   <= ack_next;
      dat_reg   <= dat_next;
    end
  end

`ifdef WB16_DECODER_ERR_EN
  // Error pulse register for unmapped and timed-out completions.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= err_next;
    end
  end
  assign m_err_o = err_reg;
`else
  assign m_err_o = 1'b0;
`endif

  assign m_ack_o = ack_reg;
  assign m_dat_o = dat_reg;
  assign s_stb_o = stb_reg;

endmodule
